// File: rtl/mult4_seq_pkg.sv
// Shared types and helpers for the nibble-serial multiply sequencer.
// Optional build macro MULT4_SEQ_ZERO_SKIP_EN (used by the pair selector) skips
// nibble pairs that have a zero operand.
package mult4_seq_pkg;

    localparam int unsigned NIB_W      = 4;
    localparam int unsigned PP_W       = 8;
    // Widest product any supported N_NIB may produce (N_NIB <= 8).
    localparam int unsigned MAX_PROD_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the pair counter k in 0..N_NIB^2-1 (at least one bit).
    function automatic int unsigned k_width(input int unsigned n_nib);
        return (n_nib * n_nib > 1) ? $clog2(n_nib * n_nib) : 1;
    endfunction

    // Partial product a_i*b_j placed at its weight 16^(i+j).
    function automatic logic [MAX_PROD_W-1:0] shift_pp(input logic [PP_W-1:0] pp,
                                                      input int unsigned i,
                                                      input int unsigned j);
        return MAX_PROD_W'(pp) << (NIB_W * (i + j));
    endfunction

endpackage

// File: rtl/mult4_seq_ctrl_if.sv
// Operand/result valid-ready bus of the multiply sequencer.
// master: operand producer + result consumer; slave: the sequencer.
interface mult4_seq_ctrl_if #(
    parameter int unsigned N_NIB = 2
);
    localparam int unsigned W = 4 * N_NIB;

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   out_prod;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_prod
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_prod
    );

endinterface

// File: rtl/mult4_seq_pair_sel.sv
// Picks the next nibble pair k to feed the shared 4x4 multiplier.
// Default build: plain increment through 0..N_NIB^2-1.
// With MULT4_SEQ_ZERO_SKIP_EN: lowest k >= search start whose a_i and b_j are both nonzero.
// start=1 searches from k=0 inclusive (job acceptance); otherwise from k+1.
// last=1 means no pair remains to visit after the search point.
module mult4_seq_pair_sel
    import mult4_seq_pkg::*;
#(
    parameter int unsigned N_NIB = 2
) (
    input  logic [NIB_W*N_NIB-1:0]    a,
    input  logic [NIB_W*N_NIB-1:0]    b,
    input  logic [k_width(N_NIB)-1:0] k,
    input  logic                      start,
    output logic [k_width(N_NIB)-1:0] nxt_k,
    output logic                      last
);

    localparam int unsigned K_W   = k_width(N_NIB);
    localparam int unsigned NPAIR = N_NIB * N_NIB;

`ifdef MULT4_SEQ_ZERO_SKIP_EN

    int unsigned lo;
    logic        found;

    // Priority search for the first nonzero pair at or after lo.
    always_comb begin
        nxt_k = '0;
        found = 1'b0;
        lo    = start ? 32'd0 : 32'(k) + 32'd1;
        for (int unsigned p = 0; p < NPAIR; p++) begin
            if (!found && (p >= lo) &&
                (a[NIB_W*(p % N_NIB) +: NIB_W] != '0) &&
                (b[NIB_W*(p / N_NIB) +: NIB_W] != '0)) begin
                found = 1'b1;
                nxt_k = K_W'(p);
            end
        end
        last = !found;
    end

`else

    // Operands only matter for the zero-skip search.
    logic unused_ops;
    assign unused_ops = ^{a, b};

    // Fixed schedule: every pair in ascending order.
    always_comb begin
        nxt_k = start ? '0 : k + K_W'(1);
        last  = !start && (32'(k) == NPAIR - 1);
    end

`endif

endmodule

// File: rtl/mult4_seq_ctrl.sv
// W x W unsigned multiply sequenced over one external combinational 4x4 multiplier.
// Each MUL cycle drives one nibble pair on mul_a/mul_b and accumulates the shifted
// product returned on mul_prod. Build macro MULT4_SEQ_ZERO_SKIP_EN (see pair selector)
// skips pairs with a zero nibble; the result is the same either way.
module mult4_seq_ctrl
    import mult4_seq_pkg::*;
#(
    parameter int unsigned N_NIB = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    mult4_seq_ctrl_if.slave  bus,
    output logic             busy,
    output logic [NIB_W-1:0] mul_a,
    output logic [NIB_W-1:0] mul_b,
    input  logic [PP_W-1:0]  mul_prod
);

    localparam int unsigned W      = NIB_W * N_NIB;
    localparam int unsigned PROD_W = 2 * W;
    localparam int unsigned K_W    = k_width(N_NIB);

    state_t            state_q, state_n;
    logic [W-1:0]      a_q, a_n, b_q, b_n;
    logic [K_W-1:0]    k_q, k_n;
    logic [PROD_W-1:0] acc_q, acc_n;
    logic [PROD_W-1:0] out_prod_q, out_prod_n;
    logic [NIB_W-1:0]  mul_a_q, mul_a_n, mul_b_q, mul_b_n;
    logic              in_ready_q, in_ready_n;
    logic              out_valid_q, out_valid_n;
    logic              busy_q, busy_n;

    logic              accept;
    logic              sel_start;
    logic [W-1:0]      sel_a, sel_b;
    logic [K_W-1:0]    sel_k;
    logic              sel_last;
    logic [PROD_W-1:0] pp_sh;

    function automatic logic [NIB_W-1:0] nib(input logic [W-1:0] v, input int unsigned idx);
        return v[NIB_W*idx +: NIB_W];
    endfunction

    // In IDLE the search runs over the incoming operands so the first pair is ready at accept.
    assign sel_start = (state_q == IDLE);
    assign sel_a     = sel_start ? bus.in_a : a_q;
    assign sel_b     = sel_start ? bus.in_b : b_q;

    mult4_seq_pair_sel #(
        .N_NIB (N_NIB)
    ) u_pair_sel (
        .a     (sel_a),
        .b     (sel_b),
        .k     (k_q),
        .start (sel_start),
        .nxt_k (sel_k),
        .last  (sel_last)
    );

    // in_ready is only ever high in IDLE.
    assign accept = bus.in_valid && in_ready_q;
    assign pp_sh  = PROD_W'(shift_pp(mul_prod, 32'(k_q) % N_NIB, 32'(k_q) / N_NIB));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Next state, datapath updates and next values of the registered outputs.
    always_comb begin
        state_n    = state_q;
        a_n        = a_q;
        b_n        = b_q;
        k_n        = k_q;
        acc_n      = acc_q;
        out_prod_n = out_prod_q;
        mul_a_n    = '0;
        mul_b_n    = '0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_n   = bus.in_a;
                    b_n   = bus.in_b;
                    acc_n = '0;
                    k_n   = sel_k;
                    if (sel_last) begin
                        // No nonzero pair at all: product is zero, skip MUL.
                        state_n    = DONE;
                        out_prod_n = '0;
                    end else begin
                        state_n = MUL;
                        mul_a_n = nib(bus.in_a, 32'(sel_k) % N_NIB);
                        mul_b_n = nib(bus.in_b, 32'(sel_k) / N_NIB);
                    end
                end
            end
            MUL: begin
                acc_n = acc_q + pp_sh;
                if (sel_last) begin
                    state_n    = DONE;
                    out_prod_n = acc_q + pp_sh;
                end else begin
                    k_n     = sel_k;
                    mul_a_n = nib(a_q, 32'(sel_k) % N_NIB);
                    mul_b_n = nib(b_q, 32'(sel_k) / N_NIB);
                end
            end
            DONE: begin
                if (out_valid_q && bus.out_ready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // A direct IDLE->DONE hop raises out_valid one clock later, keeping latency >= 1.
        out_valid_n = (state_n == DONE) && (state_q != IDLE);
        in_ready_n  = (state_n == IDLE);
        busy_n      = (state_n != IDLE);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q         <= '0;
            b_q         <= '0;
            k_q         <= '0;
            acc_q       <= '0;
            out_prod_q  <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            a_q         <= a_n;
            b_q         <= b_n;
            k_q         <= k_n;
            acc_q       <= acc_n;
            out_prod_q  <= out_prod_n;
            mul_a_q     <= mul_a_n;
            mul_b_q     <= mul_b_n;
            in_ready_q  <= in_ready_n;
            out_valid_q <= out_valid_n;
            busy_q      <= busy_n;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_prod  = out_prod_q;
    assign busy          = busy_q;
    assign mul_a         = mul_a_q;
    assign mul_b         = mul_b_q;

endmodule

// File: tb/tb_mult4_seq_ctrl.sv
// Scoreboard bench for mult4_seq_ctrl with an external behavioural 4x4 multiplier.
// Honours MULT4_SEQ_ZERO_SKIP_EN when computing expected latency.
module tb_mult4_seq_ctrl;
    import mult4_seq_pkg::*;

    localparam int unsigned N_NIB = 2;
    localparam int unsigned W     = NIB_W * N_NIB;
    localparam int unsigned PW    = 2 * W;
    localparam int unsigned NPAIR = N_NIB * N_NIB;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             busy;
    logic [NIB_W-1:0] mul_a, mul_b;
    logic [PP_W-1:0]  mul_prod;

    mult4_seq_ctrl_if #(.N_NIB(N_NIB)) bus_if ();

    mult4_seq_ctrl #(.N_NIB(N_NIB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus_if),
        .busy     (busy),
        .mul_a    (mul_a),
        .mul_b    (mul_b),
        .mul_prod (mul_prod)
    );

    // Shared 4x4 multiplier living outside the sequencer.
    assign mul_prod = 8'(mul_a) * 8'(mul_b);

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    logic [PW-1:0] exp_q[$];
    int unsigned   lat_q[$];
    int unsigned   acc_q[$];
    int unsigned   hs_cyc = 0;
    logic          prev_ov = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    endtask

    task automatic fail(input string name);
        n_total++;
        $display("FAIL %s: event not as required (t=%0t)", name, $time);
    endtask

    function automatic int unsigned exp_lat(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MULT4_SEQ_ZERO_SKIP_EN
        int unsigned n = 0;
        for (int unsigned k = 0; k < NPAIR; k++)
            if (a[NIB_W*(k % N_NIB) +: NIB_W] != 0 && b[NIB_W*(k / N_NIB) +: NIB_W] != 0) n++;
        return (n == 0) ? 1 : n;
`else
        return NPAIR;
`endif
    endfunction

    // Monitor: compare every presented result against the scoreboard head.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov = 1'b0;
        end else begin
            if (!busy) check("mul_idle_zero", 64'({mul_a, mul_b}), 64'd0);
            if (bus_if.out_valid) begin
                if (exp_q.size() == 0) begin
                    fail("unexpected_result");
                end else begin
                    if (!prev_ov) check("latency", 64'(cyc - acc_q[0]), 64'(lat_q[0]));
                    check("out_prod", 64'(bus_if.out_prod), 64'(exp_q[0]));
                    check("in_ready_in_done", 64'(bus_if.in_ready), 64'd0);
                    if (bus_if.out_ready) begin
                        void'(exp_q.pop_front());
                        void'(lat_q.pop_front());
                        void'(acc_q.pop_front());
                        hs_cyc = cyc;
                    end
                end
            end
            prev_ov = bus_if.out_valid;
        end
    end

    // Present one operand pair; called and returns at 1 time unit after a rising edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit gap_chk, input bit keep);
        bit done = 1'b0;
        bus_if.in_valid = 1'b1;
        bus_if.in_a     = a;
        bus_if.in_b     = b;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (bus_if.in_ready) begin
                exp_q.push_back(PW'(a) * PW'(b));
                lat_q.push_back(exp_lat(a, b));
                acc_q.push_back(cyc + 1);
                if (gap_chk) check("idle_gap", 64'(cyc), 64'(hs_cyc + 1));
                done = 1'b1;
            end
        end
        if (!done) fail("accept_timeout");
        @(posedge clk); #1;
        if (!keep) bus_if.in_valid = 1'b0;
    endtask

    // Expected nibble pairs in ascending k, starting the cycle after acceptance.
    task automatic check_pairs(input logic [W-1:0] a, input logic [W-1:0] b);
        for (int unsigned k = 0; k < NPAIR; k++) begin
            @(negedge clk);
            check("mul_a", 64'(mul_a), 64'(a[NIB_W*(k % N_NIB) +: NIB_W]));
            check("mul_b", 64'(mul_b), 64'(b[NIB_W*(k / N_NIB) +: NIB_W]));
        end
        @(posedge clk); #1;
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) done = 1'b1;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus_if.in_valid  = 1'b0;
        bus_if.in_a      = '0;
        bus_if.in_b      = '0;
        bus_if.out_ready = 1'b1;

        // Reset values.
        @(negedge clk);
        check("rst_in_ready", 64'(bus_if.in_ready), 64'd0);
        check("rst_out_valid", 64'(bus_if.out_valid), 64'd0);
        check("rst_out_prod", 64'(bus_if.out_prod), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_mul", 64'({mul_a, mul_b}), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("in_ready_after_rst", 64'(bus_if.in_ready), 64'd1);
        @(posedge clk); #1;

        // 1: 0xFF*0xFF, all pairs (F,F).
        send(8'hFF, 8'hFF, 1'b0, 1'b0);
        check_pairs(8'hFF, 8'hFF);
        drain();

        // 2: zero operand.
        send(8'h00, 8'h37, 1'b0, 1'b0);
        drain();

        // 3: consumer stalls 5 clocks, result held stable.
        bus_if.out_ready = 1'b0;
        send(8'h3A, 8'h5C, 1'b0, 1'b0);
        check_pairs(8'h3A, 8'h5C);
        begin
            bit seen = 1'b0;
            for (int t = 0; t < 20 && !seen; t++) begin
                @(negedge clk);
                if (bus_if.out_valid) seen = 1'b1;
            end
            if (!seen) fail("stall_valid_timeout");
        end
        for (int r = 1; r < 5; r++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("stall_out_valid", 64'(bus_if.out_valid), 64'd1);
        end
        @(posedge clk); #1;
        bus_if.out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("stall_released", 64'(bus_if.out_valid), 64'd0);
        @(posedge clk); #1;
        drain();

        // 4: in_valid pulse while busy is ignored.
        send(8'h02, 8'h03, 1'b0, 1'b0);
        bus_if.in_valid = 1'b1;
        bus_if.in_a     = 8'h11;
        bus_if.in_b     = 8'h11;
        @(negedge clk);
        check("busy_in_ready", 64'(bus_if.in_ready), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("busy_in_ready", 64'(bus_if.in_ready), 64'd0);
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        drain();

        // 5: async reset mid-operation discards the job.
        send(8'h77, 8'h77, 1'b0, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b0;
        exp_q.delete();
        lat_q.delete();
        acc_q.delete();
        @(negedge clk);
        check("midrst_out_valid", 64'(bus_if.out_valid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_mul", 64'({mul_a, mul_b}), 64'd0);
        check("midrst_in_ready", 64'(bus_if.in_ready), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        send(8'h10, 8'h10, 1'b0, 1'b0);
        drain();

        // 6: back-to-back random jobs with in_valid held high.
        for (int n = 0; n < 1000; n++) begin
            send(W'($urandom), W'($urandom), n > 0, n < 999);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
